// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the bit-serial datapath.
//  CPU_WIDTH : datapath/register width
//  alu_op_e  : ALU operation encoding (11x reserved, treated as PASS)
//  state_e   : serial ALU sequencer states
package cpu_pkg;

  localparam int unsigned CPU_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_PASS = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_STORE
  } state_e;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit combinational ALU slice for the serial ALU.
//  a, b      : operand bits (b is the raw operand; inversion for SUB is done here)
//  carry_in  : carry from the previous (less significant) bit
//  op        : alu_op_e encoding; unknown codes behave as PASS(A)
//  r         : result bit
//  carry_out : next carry (arithmetic ops only; logic ops pass carry_in through)
module alu_bit_slice
  import cpu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carry_in,
  input  logic [2:0] op,
  output logic       r,
  output logic       carry_out
);

  logic b_eff;

  always_comb begin
    r         = a;
    carry_out = carry_in;
    b_eff     = b;
    case (op)
      OP_ADD, OP_SUB: begin
        b_eff     = (op == OP_SUB) ? ~b : b;
        r         = a ^ b_eff ^ carry_in;
        carry_out = (a & b_eff) | (a & carry_in) | (b_eff & carry_in);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU and accumulator sitting downstream of the serial register file.
// Walks the regfile through WIDTH shift pulses, consumes rs1/rs2 bits LSB-first,
// shifts results into the accumulator, then strobes a parallel store back to rs1.
// Optional feature macro: ALU_FLAGS_EN (adds flag_z/flag_c/flag_n outputs).
// Ports:
//  clk, rst      : clock (rising edge), asynchronous active-high reset
//  start         : launch an operation (sampled only in IDLE)
//  alu_op        : operation code (see cpu_pkg::alu_op_e)
//  b_sel         : 0 -> B from rs2_bit, 1 -> B from serialised imm
//  imm           : immediate, captured on accepted start
//  rs1_bit       : operand A bit from regfile
//  rs2_bit       : operand B bit from regfile
//  reg_shift_en  : advance regfile bit index (EXEC only)
//  reg_store_en  : one-cycle parallel store strobe
//  wr_bit        : current result bit (combinational, 0 outside EXEC)
//  acc_bits      : accumulator, to regfile parallel store
//  busy          : high in EXEC and STORE
//  done          : one-cycle pulse in the first IDLE cycle after STORE
//  flag_z/c/n    : zero / carry (no-borrow for SUB) / negative, updated in STORE
module alu_serial
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = CPU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic             b_sel,
  input  logic [WIDTH-1:0] imm,
  input  logic             rs1_bit,
  input  logic             rs2_bit,
  output logic             reg_shift_en,
  output logic             reg_store_en,
  output logic             wr_bit,
  output logic [WIDTH-1:0] acc_bits,
`ifdef ALU_FLAGS_EN
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
`endif
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [2:0]       op_q;
  logic             b_sel_q;
  logic [WIDTH-1:0] imm_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic b_bit;
  logic r;
  logic carry_nxt;

  assign b_bit = b_sel_q ? imm_sr[0] : rs2_bit;

  alu_bit_slice u_slice (
    .a         (rs1_bit),
    .b         (b_bit),
    .carry_in  (carry),
    .op        (op_q),
    .r         (r),
    .carry_out (carry_nxt)
  );

  assign wr_bit = (state == ST_EXEC) ? r : 1'b0;

  // Strobes are registered alongside the state transitions so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      op_q         <= '0;
      b_sel_q      <= 1'b0;
      imm_sr       <= '0;
      carry        <= 1'b0;
      cnt          <= '0;
      acc_bits     <= '0;
      reg_shift_en <= 1'b0;
      reg_store_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef ALU_FLAGS_EN
      flag_z       <= 1'b0;
      flag_c       <= 1'b0;
      flag_n       <= 1'b0;
`endif
    end else begin
      done         <= 1'b0;
      reg_store_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_EXEC;
            op_q         <= alu_op;
            b_sel_q      <= b_sel;
            imm_sr       <= imm;
            carry        <= (alu_op == OP_SUB);
            cnt          <= '0;
            reg_shift_en <= 1'b1;
            busy         <= 1'b1;
          end
        end
        ST_EXEC: begin
          acc_bits <= {r, acc_bits[WIDTH-1:1]};
          imm_sr   <= imm_sr >> 1;
          carry    <= carry_nxt;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST) begin
            state        <= ST_STORE;
            reg_shift_en <= 1'b0;
            reg_store_en <= 1'b1;
          end
        end
        ST_STORE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
`ifdef ALU_FLAGS_EN
          flag_z <= (acc_bits == '0);
          flag_n <= acc_bits[WIDTH-1];
          flag_c <= carry;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
